multicycle_control_unit: RTL and testbench

Sequencing controller for the multi-cycle RISC-V core. It walks each instruction through fetch, decode, execute, memory and writeback states, and drives the shared ALU's 2-bit ALU operation code into the ALU control decoder. It also drives the datapath mux selects, register and memory enables, and the memory request handshake. Supported instructions are R-type (add, sub, and, or), ld, sd and beq. Illegal opcodes and memory timeouts trap.

---
 rtl/multicycle_control_unit_if.sv | 21 ++
 rtl/multicycle_control_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Memory request handshake between the multi-cycle controller and the memory.
//   memRequest : controller asks for an access (held until memReady)
//   memWrite   : with memRequest, 1 = store, 0 = read
//   memReady   : memory completion strobe for the current request
interface multicycle_control_unit_if;
  logic memRequest;
  logic memWrite;
  logic memReady;

  modport master (
    output memRequest,
    output memWrite,
    input  memReady
  );

  modport slave (
    input  memRequest,
    input  memWrite,
    output memReady
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Sequencing controller for the multi-cycle RISC-V core (R-type, ld, sd, beq).
// Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives
// datapath selects, enables, the ALU operation code and the memory handshake.
// Ports:
//   clock, resetN      : clock, asynchronous active-low reset
//   mem (master)       : memRequest/memWrite out, memReady in
//   opcodeInput        : opcode field of the instruction register
//   zeroInput          : ALU zero flag, used in BRANCH
//   irWrite, pcWrite   : IR / PC load enables (depend on memReady / zeroInput)
//   pcSource, ALUOperationOutput, ALUSrcA, ALUSrcB, regWrite, memToReg
//                      : registered per-state datapath controls
//   retire             : pulse on the final cycle of an instruction
//   illegalInstruction, busError : sticky trap flags
//   stateOutput        : current state encoding for debug
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                       clock,
  input  logic                       resetN,
  multicycle_control_unit_if.master  mem,
  input  logic [6:0]                 opcodeInput,
  input  logic                       zeroInput,
  output logic                       irWrite,
  output logic                       pcWrite,
  output logic                       pcSource,
  output logic [1:0]                 ALUOperationOutput,
  output logic                       ALUSrcA,
  output logic [1:0]                 ALUSrcB,
  output logic                       regWrite,
  output logic                       memToReg,
  output logic                       retire,
  output logic                       illegalInstruction,
  output logic                       busError,
  output logic [3:0]                 stateOutput
);

  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned STATE_W = 4;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADDR  = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECUTE  = 4'd7,
    RWB      = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } state_e;

  // Moore datapath controls, registered from the next state.
  typedef struct packed {
    logic       memRequest;
    logic       memWrite;
    logic       pcSource;
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       regWrite;
    logic       memToReg;
  } ctrl_t;

  state_e              state_q, state_d;
  logic                run_q;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                ill_q, ill_d;
  logic                bus_q, bus_d;
  ctrl_t               ctrl_q, ctrl_d;

  logic                mem_state_c;
  logic                timeout_c;

  // States that hold a memory request open and therefore count wait cycles.
  assign mem_state_c = (state_q == FETCH) || (state_q == MEMREAD) ||
                       (state_q == MEMWRITE);

  // Last permitted wait cycle: memReady still low here means a bus error.
  assign timeout_c = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Next-state, wait counter, sticky flags and next Moore controls.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ill_d   = ill_q;
    bus_d   = bus_q;
    ctrl_d  = '0;

    case (state_q)
      // Hold IDLE for one edge after reset release before the first fetch.
      IDLE: if (run_q) state_d = FETCH;

      FETCH: begin
        if (mem.memReady) begin
          state_d = DECODE;
        end else if (timeout_c) begin
          state_d = TRAP;
          bus_d   = 1'b1;
        end
      end

      DECODE: begin
        case (opcodeInput)
          OP_LD, OP_SD: state_d = MEMADDR;
          OP_R:         state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          default: begin
            state_d = TRAP;
            ill_d   = 1'b1;
          end
        endcase
      end

      MEMADDR: state_d = (opcodeInput == OP_SD) ? MEMWRITE : MEMREAD;

      MEMREAD: begin
        if (mem.memReady) begin
          state_d = MEMWB;
        end else if (timeout_c) begin
          state_d = TRAP;
          bus_d   = 1'b1;
        end
      end

      MEMWRITE: begin
        if (mem.memReady) begin
          state_d = FETCH;
        end else if (timeout_c) begin
          state_d = TRAP;
          bus_d   = 1'b1;
        end
      end

      MEMWB:   state_d = FETCH;
      EXECUTE: state_d = RWB;
      RWB:     state_d = FETCH;
      BRANCH:  state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase

    // Counter restarts on every state change; a ready cycle ends the wait.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_state_c && !mem.memReady) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    case (state_d)
      FETCH: begin
        ctrl_d.memRequest = 1'b1;
        ctrl_d.aluSrcB    = 2'b01;
      end
      // Branch target (PC + imm) is precomputed into ALUOut here.
      DECODE: begin
        ctrl_d.aluSrcB = 2'b10;
      end
      MEMADDR: begin
        ctrl_d.aluSrcA = 1'b1;
        ctrl_d.aluSrcB = 2'b10;
      end
      MEMREAD: begin
        ctrl_d.memRequest = 1'b1;
      end
      MEMWRITE: begin
        ctrl_d.memRequest = 1'b1;
        ctrl_d.memWrite   = 1'b1;
      end
      MEMWB: begin
        ctrl_d.regWrite = 1'b1;
        ctrl_d.memToReg = 1'b1;
      end
      EXECUTE: begin
        ctrl_d.aluSrcA = 1'b1;
        ctrl_d.aluOp   = 2'b10;
      end
      RWB: begin
        ctrl_d.regWrite = 1'b1;
      end
      BRANCH: begin
        ctrl_d.aluSrcA  = 1'b1;
        ctrl_d.aluOp    = 2'b01;
        ctrl_d.pcSource = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // State, counter, flags and controls; reset forces every control low.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      wait_q  <= '0;
      ill_q   <= 1'b0;
      bus_q   <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      wait_q  <= wait_d;
      ill_q   <= ill_d;
      bus_q   <= bus_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign mem.memRequest     = ctrl_q.memRequest;
  assign mem.memWrite       = ctrl_q.memWrite;
  assign pcSource           = ctrl_q.pcSource;
  assign ALUOperationOutput = ctrl_q.aluOp;
  assign ALUSrcA            = ctrl_q.aluSrcA;
  assign ALUSrcB            = ctrl_q.aluSrcB;
  assign regWrite           = ctrl_q.regWrite;
  assign memToReg           = ctrl_q.memToReg;

  // Enables that must react to memReady / zeroInput within the same cycle.
  assign irWrite = (state_q == FETCH) && mem.memReady;
  assign pcWrite = irWrite || ((state_q == BRANCH) && zeroInput);
  assign retire  = ((state_q == MEMWRITE) && mem.memReady) ||
                   (state_q == MEMWB) || (state_q == RWB) ||
                   (state_q == BRANCH);

  assign illegalInstruction = ill_q;
  assign busError           = bus_q;
  assign stateOutput        = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (MEM_TIMEOUT = 4).
module tb_multicycle_control_unit;

  localparam int unsigned TIMEOUT = 4;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_MEMADDR = 4'd3, S_MEMREAD = 4'd4, S_MEMWB = 4'd5,
                         S_MEMWRITE = 4'd6, S_EXECUTE = 4'd7, S_RWB = 4'd8,
                         S_BRANCH = 4'd9, S_TRAP = 4'd10;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0010011;

  typedef struct packed {
    logic       memRequest;
    logic       memWrite;
    logic       irWrite;
    logic       pcWrite;
    logic       pcSource;
    logic [1:0] aluOp;
    logic       srcA;
    logic [1:0] srcB;
    logic       regWrite;
    logic       memToReg;
    logic       retire;
    logic       ill;
    logic       bus;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic       zero;
    int         fwait;
    int         mwait;
    int         exp_lat;
  } vec_t;

  logic       clock;
  logic       resetN;
  logic [6:0] opcodeInput;
  logic       zeroInput;
  logic       irWrite, pcWrite, pcSource, ALUSrcA, regWrite, memToReg;
  logic       retire, illegalInstruction, busError;
  logic [1:0] ALUOperationOutput, ALUSrcB;
  logic [3:0] stateOutput;

  multicycle_control_unit_if mif ();

  multicycle_control_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clock              (clock),
    .resetN             (resetN),
    .mem                (mif),
    .opcodeInput        (opcodeInput),
    .zeroInput          (zeroInput),
    .irWrite            (irWrite),
    .pcWrite            (pcWrite),
    .pcSource           (pcSource),
    .ALUOperationOutput (ALUOperationOutput),
    .ALUSrcA            (ALUSrcA),
    .ALUSrcB            (ALUSrcB),
    .regWrite           (regWrite),
    .memToReg           (memToReg),
    .retire             (retire),
    .illegalInstruction (illegalInstruction),
    .busError           (busError),
    .stateOutput        (stateOutput)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  obs_t act;
  assign act = {mif.memRequest, mif.memWrite, irWrite, pcWrite, pcSource,
                ALUOperationOutput, ALUSrcA, ALUSrcB, regWrite, memToReg,
                retire, illegalInstruction, busError, stateOutput};

  int         checks = 0;
  int         errors = 0;
  obs_t       sb[$];
  logic       ill_e = 1'b0;
  logic       bus_e = 1'b0;
  logic [3:0] prev_state = S_IDLE;
  int         fetch_cnt = 0;
  int         retire_cnt = 0;
  vec_t       vecs[11];

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Expected outputs straight from the per-state output table.
  function automatic obs_t spec_out(input logic [3:0] st, input logic rdy,
                                    input logic z, input logic ill,
                                    input logic bus);
    obs_t o;
    o = '0;
    case (st)
      S_FETCH: begin
        o.memRequest = 1'b1; o.srcB = 2'b01; o.irWrite = rdy; o.pcWrite = rdy;
      end
      S_DECODE:   o.srcB = 2'b10;
      S_MEMADDR:  begin o.srcA = 1'b1; o.srcB = 2'b10; end
      S_MEMREAD:  o.memRequest = 1'b1;
      S_MEMWRITE: begin o.memRequest = 1'b1; o.memWrite = 1'b1; o.retire = rdy; end
      S_MEMWB:    begin o.regWrite = 1'b1; o.memToReg = 1'b1; o.retire = 1'b1; end
      S_EXECUTE:  begin o.srcA = 1'b1; o.aluOp = 2'b10; end
      S_RWB:      begin o.regWrite = 1'b1; o.retire = 1'b1; end
      S_BRANCH: begin
        o.srcA = 1'b1; o.aluOp = 2'b01; o.pcSource = 1'b1; o.pcWrite = z;
        o.retire = 1'b1;
      end
      default: o = '0;
    endcase
    o.ill   = ill;
    o.bus   = bus;
    o.state = st;
    return o;
  endfunction

  task automatic check(input string label, input obs_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", label, act, e, $time);
    end
  endtask

  // One clock cycle: queue expectation, drive, sample mid-cycle, compare.
  task automatic step(input string label, input logic [3:0] st,
                      input logic rdy, input logic z);
    obs_t e;
    sb.push_back(spec_out(st, rdy, z, ill_e, bus_e));
    mif.memReady = rdy;
    zeroInput    = z;
    #3;
    e = sb.pop_front();
    check(label, e);
    if (act.state == S_FETCH && prev_state != S_FETCH) fetch_cnt = 0;
    fetch_cnt++;
    prev_state = act.state;
    retire_cnt += int'(act.retire);
    @(posedge clock);
    #1;
  endtask

  // Asynchronous reset mid-cycle, then two IDLE cycles after release.
  task automatic do_reset(input string label);
    resetN = 1'b0;
    ill_e  = 1'b0;
    bus_e  = 1'b0;
    #1;
    check(label, spec_out(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clock);
    #1;
    check("held in reset", spec_out(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
    resetN = 1'b1;
    step("release cycle 1", S_IDLE, rbit(), rbit());
    step("release cycle 2", S_IDLE, rbit(), rbit());
  endtask

  task automatic run_vec(input vec_t v);
    opcodeInput = v.op;
    retire_cnt  = 0;
    for (int i = 0; i < v.fwait; i++) step({v.name, " fetch wait"}, S_FETCH, 1'b0, rbit());
    step({v.name, " fetch"}, S_FETCH, 1'b1, rbit());
    step({v.name, " decode"}, S_DECODE, rbit(), v.zero);
    case (v.op)
      OP_LD: begin
        step({v.name, " memaddr"}, S_MEMADDR, rbit(), v.zero);
        for (int i = 0; i < v.mwait; i++) step({v.name, " read wait"}, S_MEMREAD, 1'b0, v.zero);
        step({v.name, " read"}, S_MEMREAD, 1'b1, v.zero);
        step({v.name, " memwb"}, S_MEMWB, rbit(), v.zero);
      end
      OP_SD: begin
        step({v.name, " memaddr"}, S_MEMADDR, rbit(), v.zero);
        for (int i = 0; i < v.mwait; i++) step({v.name, " write wait"}, S_MEMWRITE, 1'b0, v.zero);
        step({v.name, " write"}, S_MEMWRITE, 1'b1, v.zero);
      end
      OP_R: begin
        step({v.name, " execute"}, S_EXECUTE, rbit(), v.zero);
        step({v.name, " rwb"}, S_RWB, rbit(), v.zero);
      end
      default: step({v.name, " branch"}, S_BRANCH, rbit(), v.zero);
    endcase
    #2;
    checks++;
    if (stateOutput !== S_FETCH || fetch_cnt != v.exp_lat) begin
      errors++;
      $display("FAIL %s latency: got state %0d after %0d cycles, expected FETCH after %0d",
               v.name, stateOutput, fetch_cnt, v.exp_lat);
    end
    checks++;
    if (retire_cnt != 1) begin
      errors++;
      $display("FAIL %s retire count: got %0d expected 1", v.name, retire_cnt);
    end
  endtask

  initial begin
    vecs[0]  = '{"add",        OP_R,   1'b0, 0, 0, 4};
    vecs[1]  = '{"sub",        OP_R,   1'b1, 0, 0, 4};
    vecs[2]  = '{"beq taken",  OP_BEQ, 1'b1, 0, 0, 3};
    vecs[3]  = '{"beq nt",     OP_BEQ, 1'b0, 0, 0, 3};
    vecs[4]  = '{"sd",         OP_SD,  1'b0, 0, 0, 4};
    vecs[5]  = '{"ld",         OP_LD,  1'b0, 0, 0, 5};
    vecs[6]  = '{"ld w2w2",    OP_LD,  1'b1, 2, 2, 9};
    vecs[7]  = '{"sd late rdy", OP_SD, 1'b0, 0, 3, 7};
    vecs[8]  = '{"ld w3w3",    OP_LD,  1'b0, 3, 3, 11};
    vecs[9]  = '{"r w3",       OP_R,   1'b0, 3, 0, 7};
    vecs[10] = '{"beq w1",     OP_BEQ, 1'b1, 1, 0, 4};

    resetN       = 1'b0;
    opcodeInput  = '0;
    zeroInput    = 1'b0;
    mif.memReady = 1'b0;
    #2;
    do_reset("power-on reset");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Unknown opcode traps and stays silent.
    opcodeInput = OP_BAD;
    step("illegal fetch", S_FETCH, 1'b1, 1'b0);
    step("illegal decode", S_DECODE, rbit(), rbit());
    ill_e = 1'b1;
    for (int i = 0; i < 21; i++) step("illegal trap", S_TRAP, rbit(), rbit());
    do_reset("reset from illegal trap");

    // Store whose memReady never arrives.
    opcodeInput = OP_SD;
    step("sd timeout fetch", S_FETCH, 1'b1, 1'b0);
    step("sd timeout decode", S_DECODE, rbit(), 1'b0);
    step("sd timeout memaddr", S_MEMADDR, rbit(), 1'b0);
    for (int i = 0; i < TIMEOUT; i++) step("sd timeout wait", S_MEMWRITE, 1'b0, 1'b0);
    bus_e = 1'b1;
    for (int i = 0; i < 3; i++) step("sd timeout trap", S_TRAP, rbit(), rbit());
    do_reset("reset from bus error");

    // Fetch that never completes.
    for (int i = 0; i < TIMEOUT; i++) step("fetch timeout wait", S_FETCH, 1'b0, 1'b0);
    bus_e = 1'b1;
    step("fetch timeout trap", S_TRAP, rbit(), rbit());
    do_reset("reset from fetch timeout");

    // Reset dropped while a load waits in MEMREAD.
    opcodeInput = OP_LD;
    step("abort fetch", S_FETCH, 1'b1, 1'b0);
    step("abort decode", S_DECODE, 1'b0, 1'b0);
    step("abort memaddr", S_MEMADDR, 1'b0, 1'b0);
    step("abort memread", S_MEMREAD, 1'b0, 1'b0);
    step("abort memread", S_MEMREAD, 1'b0, 1'b0);
    do_reset("async reset in MEMREAD");
    run_vec(vecs[5]);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
